// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver driven by an OVERSAMPLE x baud clock enable.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_meta_q, rx_s_q;

    // Two-flop synchronizer runs every clk so its latency is independent of clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clk_en && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end

            S_START: begin
                if (clk_en) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (clk_en) begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (clk_en) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            // A held-low line (break) must return high before a new start is accepted.
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx (table vectors + random frames).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en = 1'b0;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         gap;
        int         hold;
        bit         exp_valid;
        bit         exp_err;
    } vec_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         div        = 4;
    int         div_cnt    = 0;
    int         tick_ctr   = 0;
    int         valid_tick = 0;
    bit         prev_pulse = 1'b0;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk wide, every div clks.
    always @(negedge clk) begin
        if (div_cnt + 1 >= div) begin
            clk_en  = 1'b1;
            div_cnt = 0;
        end else begin
            clk_en  = 1'b0;
            div_cnt = div_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (clk_en) tick_ctr <= tick_ctr + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every pulse must match the next expected event in order.
    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                check("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
                check("pulse_one_clk", 32'(prev_pulse), 32'd0);
                if (exp_q.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL unexpected_pulse actual valid=%0b ferr=%0b required none at %0t",
                             rx_valid, frame_err, $time);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("pulse_kind_ferr", 32'(frame_err), 32'(ev.is_err));
                    if (!ev.is_err) begin
                        check("rx_data_frame", 32'(rx_data), 32'(ev.data));
                        check("busy_at_valid", 32'(busy), 32'd0);
                        model_data = ev.data;
                        valid_tick = tick_ctr;
                    end
                end
            end
            check("rx_data_hold", 32'(rx_data), 32'(model_data));
            prev_pulse = rx_valid | frame_err;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!clk_en);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(OS);
        end
        rx = stop;
        wait_ticks(OS);
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit good);
        ev_t ev;
        ev.is_err = !good;
        ev.data   = d;
        exp_q.push_back(ev);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        int t0;

        vecs[0] = '{8'h00, 1'b1, 0,  0,    1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 0,  0,    1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 0,  0,    1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 20, 0,    1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b1, 0,  0,    1'b1, 1'b0};
        vecs[5] = '{8'hAA, 1'b1, 20, 0,    1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 0,  3*OS, 1'b0, 1'b1};
        vecs[7] = '{8'h5A, 1'b1, 20, 0,    1'b1, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // Single frame, latency measured from the tick before the start edge.
        t0 = tick_ctr;
        expect_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        drain("a5_drain");
        check("a5_latency_ticks", 32'(valid_tick - t0), 32'd153);
        check("a5_idle_after", 32'(busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_valid) expect_frame(vecs[v].data, 1'b1);
            if (vecs[v].exp_err)   expect_frame(8'h00, 1'b0);
            send_frame(vecs[v].data, vecs[v].stop);
            if (!vecs[v].stop) begin
                rx = 1'b0;
                wait_ticks(vecs[v].hold / 2);
                check("break_busy", 32'(busy), 32'd1);
                wait_ticks(vecs[v].hold - vecs[v].hold / 2);
                rx = 1'b1;
                wait_ticks(OS);
                check("break_released_idle", 32'(busy), 32'd0);
            end
            rx = 1'b1;
            if (vecs[v].gap > 0) wait_ticks(vecs[v].gap);
        end
        drain("table_drain");

        // Glitch shorter than half a bit.
        rx = 1'b0;
        wait_ticks(5);
        check("glitch_start_seen", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_ticks(OS);
        check("glitch_idle", 32'(busy), 32'd0);
        drain("glitch_no_pulse");

        // Reset during data bit 4.
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx = 8'hE7 >> i;
            wait_ticks(OS);
        end
        rx = 1'b0;
        wait_ticks(OS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_ticks(2 * OS);
        expect_frame(8'hC3, 1'b1);
        send_frame(8'hC3, 1'b1);
        drain("c3_drain");

        // Randomized frames checked against the event model.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         good;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 7) != 0);
            gap  = $urandom_range(0, 24);
            if ($urandom_range(0, 3) == 0) div = $urandom_range(1, 4);
            expect_frame(d, good);
            send_frame(d, good);
            if (!good) begin
                rx = 1'b0;
                wait_ticks(OS * $urandom_range(1, 3));
                rx = 1'b1;
                wait_ticks(OS);
            end
            rx = 1'b1;
            if (gap > 0) wait_ticks(gap);
        end
        drain("random_drain");
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). This is the receive counterpart of the team's uart_tx.
- Samples the asynchronous rx line using an oversampling enable (clk_en at OVERSAMPLE x baud) from the shared baud generator.
- Validates the start bit at its mid-point and samples each data bit at its centre.
- Presents each received byte with a single-cycle valid strobe, and flags framing errors.

Parameters:
- OVERSAMPLE, 16, clk_en ticks per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clk_en  input  1  oversample tick, one clk wide, OVERSAMPLE pulses per bit.
- rx  input  1  asynchronous UART RX line; idles high.
- rx_data  output  8  last correctly received byte; holds until the next good frame.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, synchronizer flops=1, tick_cnt=0, bit_idx=0, shift=0.
- Reset timing: reset wins over all other activity in the same cycle. Reset mid-frame aborts the frame with no rx_valid or frame_err pulse.
- Input synchronizer: rx passes through two flops, clocked every clk (not gated by clk_en), giving rx_s. All decisions use rx_s only, so detection latency is 2 clk.
- Tick counting: tick_cnt, width clog2(OVERSAMPLE), advances only on clk_en cycles. bit_idx is 3 bits. State transitions occur only on clk_en cycles, except WAIT_IDLE exit.
- IDLE:
  - On clk_en with rx_s==0: go to START, tick_cnt=0.
- START:
  - On clk_en: tick_cnt++.
  - When tick_cnt==OVERSAMPLE/2-1 (mid start bit) and rx_s==0: go to DATA, tick_cnt=0, bit_idx=0.
  - When tick_cnt==OVERSAMPLE/2-1 and rx_s==1: treat as a glitch and return to IDLE silently.
- DATA:
  - On clk_en: tick_cnt++.
  - When tick_cnt==OVERSAMPLE-1: shift={rx_s, shift[7:1]} (LSB-first), tick_cnt=0, bit_idx++.
  - After the sample with bit_idx==7: go to STOP.
- STOP:
  - On clk_en: tick_cnt++.
  - When tick_cnt==OVERSAMPLE-1 and rx_s==1: rx_data<=shift, rx_valid=1 for the next clk only, go to IDLE.
  - When tick_cnt==OVERSAMPLE-1 and rx_s==0: frame_err=1 for one clk, rx_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1 (checked every clk), then go to IDLE.
  - Purpose: a break condition (line held low) never produces spurious frames.
- Sampling points: start sample at OVERSAMPLE/2 ticks after the falling edge is detected. Data and stop samples follow at +OVERSAMPLE tick intervals.
- Latency: rx_valid rises OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start detection (152 ticks at default), plus one clk.
- Back-to-back frames: a stop bit followed immediately by the next start bit must be received. The state is IDLE from mid-stop, so the next falling edge is caught.
- Output exclusivity: rx_valid and frame_err are never asserted together. Neither is asserted outside the STOP exit cycle.
- clk_en stuck low: all state freezes. clk_en high every clk is legal.

Test Plan:
- Frame 0xA5, clk_en every 4 clk, 16 ticks/bit -> rx_data=0xA5, rx_valid high exactly 1 clk, frame_err=0, busy low after the pulse.
- Frames 0x00, 0xFF, 0x01, 0x80 back-to-back with no idle gap -> four rx_valid pulses in order with matching rx_data, no frame_err.
- rx low for 5 ticks, then high (glitch shorter than half a bit) -> return to IDLE, no rx_valid, no frame_err, rx_data unchanged.
- Frame 0x3C with the stop bit driven low, line held low 3 bit times, then released -> one frame_err pulse, rx_data keeps its prior value, no new frame until the line returns high; a following frame 0x5A is received correctly.
- rst asserted during data bit 4 of a frame -> next clk: state IDLE, busy=0, rx_data=0x00, no pulses. A subsequent clean frame 0xC3 is received correctly.
- Loopback from uart_tx with a matching bit period, bytes 0x55 then 0xAA -> rx_data matches both bytes, with 2 rx_valid pulses.
